seq_detect_sched: RTL and testbench

//  Shares one bit-serial 1001 sequence detector between NUM_CH requesters.
//  - Each requester offers a WIDTH-bit word. Arbitration is round-robin.
//  - The winning word is serialized MSB-first into the detector.
//  - The controller counts detections for that word and returns the count with the channel id.
//  - Sits between the stream sources and the shared detector.

---
 rtl/seq_detect_sched.sv | 137 +++++++++++++
 tb/tb_seq_detect_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// seq_detect_sched
//   Shares one external bit-serial "1001" detector between NUM_CH requesters.
//   A round-robin arbiter grants one request word. The word is shifted MSB-first
//   into the detector, and the detections seen for it are counted (saturating).
//   The count is then reported together with the channel id.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_data  per-channel request; channel i at req_data[i*WIDTH +: WIDTH]
//   req_ready           one-hot grant, combinational, handshake in the same cycle
//   det_bit/det_rst     serial bit and synchronous reset driven to the detector
//   det_seen            detector hit, high the cycle after the 4th matching bit
//   res_valid/res_ready result handshake; res_ch/res_count carry the result
//   busy                high whenever the controller is not idle
module seq_detect_sched #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned CNT_W  = 4,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       req_valid,
   input  logic [NUM_CH*WIDTH-1:0] req_data,
   output logic [NUM_CH-1:0]       req_ready,
   output logic                    det_bit,
   output logic                    det_rst,
   input  logic                    det_seen,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [CH_W-1:0]         res_ch,
   output logic [CNT_W-1:0]        res_count,
   output logic                    busy
);

   localparam int unsigned BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StReport} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CH_W-1:0]   res_ch_q, res_ch_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [CH_W-1:0]   win;
   logic              win_ok;
   logic              grant;
   int unsigned       idx;

   // First valid channel searching upward from rr_ptr, wrapping.
   always_comb begin
      win    = '0;
      win_ok = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!win_ok && req_valid[idx]) begin
            win_ok = 1'b1;
            win    = CH_W'(idx);
         end
      end
   end

   // No handshake may complete while reset is held.
   assign grant     = (state_q == StIdle) && win_ok && !reset;
   assign req_ready = grant ? (NUM_CH'(1) << win) : '0;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      count_d  = count_q;
      res_ch_d = res_ch_q;
      rr_ptr_d = rr_ptr_q;

      unique case (state_q)
         StIdle: begin
            if (grant) begin
               shreg_d  = req_data[win*WIDTH +: WIDTH];
               res_ch_d = win;
               rr_ptr_d = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
               count_d  = '0;
               state_d  = StClear;
            end
         end
         StClear: begin
            bitcnt_d = BC_W'(WIDTH - 1);
            state_d  = StShift;
         end
         StShift: begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - 1'b1;
            if (bitcnt_q == '0) state_d = StDrain;
         end
         StDrain: begin
            state_d = StReport;
         end
         StReport: begin
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Saturating hit counter; DRAIN catches the hit for the final bit.
      if ((state_q == StShift || state_q == StDrain) && det_seen && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         count_q  <= '0;
         res_ch_q <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         count_q  <= count_d;
         res_ch_q <= res_ch_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign det_rst   = reset | (state_q == StClear);
   assign det_bit   = (state_q == StShift) ? shreg_q[WIDTH-1] : 1'b0;
   assign res_valid = (state_q == StReport);
   assign res_ch    = res_ch_q;
   assign res_count = count_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Testbench for seq_detect_sched: two instances (4-bit and 2-bit counters) share stimulus.
// A transaction-level model predicts the grants, the serial bits, the result timing and the counts.
module tb_seq_detect_sched;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned WIDTH  = 16;
   localparam int unsigned LAT    = WIDTH + 3;

   logic                    clk;
   logic                    reset;
   logic [NUM_CH-1:0]       req_valid;
   logic [NUM_CH*WIDTH-1:0] req_data;
   logic                    res_ready;

   logic [NUM_CH-1:0] rdy_a, rdy_s;
   logic              bit_a, bit_s, drst_a, drst_s, seen_a, seen_s;
   logic              rv_a, rv_s, busy_a, busy_s;
   logic              ch_a, ch_s;
   logic [3:0]        cnt_a;
   logic [1:0]        cnt_s;

   seq_detect_sched #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(rdy_a), .det_bit(bit_a), .det_rst(drst_a), .det_seen(seen_a),
      .res_valid(rv_a), .res_ready(res_ready), .res_ch(ch_a), .res_count(cnt_a),
      .busy(busy_a)
   );

   seq_detect_sched #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(2)) u_dut_s (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(rdy_s), .det_bit(bit_s), .det_rst(drst_s), .det_seen(seen_s),
      .res_valid(rv_s), .res_ready(res_ready), .res_ch(ch_s), .res_count(cnt_s),
      .busy(busy_s)
   );

   // External overlapping 1001 detectors, one per instance.
   logic [2:0] hist_a, hist_s;
   always_ff @(posedge clk) begin
      if (drst_a) begin
         hist_a <= '0;
         seen_a <= 1'b0;
      end else begin
         hist_a <= {hist_a[1:0], bit_a};
         seen_a <= ({hist_a, bit_a} == 4'b1001);
      end
   end
   always_ff @(posedge clk) begin
      if (drst_s) begin
         hist_s <= '0;
         seen_s <= 1'b0;
      end else begin
         hist_s <= {hist_s[1:0], bit_s};
         seen_s <= ({hist_s, bit_s} == 4'b1001);
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_count(input logic [WIDTH-1:0] w);
      int c = 0;
      for (int i = WIDTH - 1; i >= 3; i--) begin
         if (w[i -: 4] == 4'b1001) c++;
      end
      return c;
   endfunction

   // Model state
   int               cyc = 0;
   bit               m_idle = 1'b1;
   int               m_rr = 0;
   int               t_grant = 0;
   int               exp_ch = 0;
   int               exp_cnt_a = 0;
   int               exp_cnt_s = 0;
   logic [WIDTH-1:0] exp_word = '0;

   task automatic tick(input logic rst_v, input logic [NUM_CH-1:0] v,
                       input logic [NUM_CH*WIDTH-1:0] d, input logic rr);
      int w;
      int age;
      int c;
      logic [NUM_CH-1:0] exp_rdy;
      @(negedge clk);
      reset     = rst_v;
      req_valid = v;
      req_data  = d;
      res_ready = rr;
      #1;
      if (rst_v) begin
         check("det_rst_in_reset", {31'b0, drst_a}, 32'd1);
         check("ready_in_reset", {30'b0, rdy_a}, 32'd0);
         m_idle = 1'b1;
         m_rr   = 0;
      end else if (m_idle) begin
         check("idle_busy", {31'b0, busy_a}, 32'd0);
         check("idle_res_valid", {31'b0, rv_a}, 32'd0);
         check("idle_det_rst", {31'b0, drst_a}, 32'd0);
         check("idle_det_bit", {31'b0, bit_a}, 32'd0);
         w = -1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (w < 0 && v[(m_rr + k) % NUM_CH]) w = (m_rr + k) % NUM_CH;
         end
         exp_rdy = (w >= 0) ? (NUM_CH'(1) << w) : '0;
         check("grant_a", {30'b0, rdy_a}, {30'b0, exp_rdy});
         check("grant_s", {30'b0, rdy_s}, {30'b0, exp_rdy});
         if (w >= 0) begin
            exp_word  = d[w*WIDTH +: WIDTH];
            exp_ch    = w;
            c         = ref_count(exp_word);
            exp_cnt_a = (c > 15) ? 15 : c;
            exp_cnt_s = (c > 3) ? 3 : c;
            m_rr      = (w + 1) % NUM_CH;
            m_idle    = 1'b0;
            t_grant   = cyc;
         end
      end else begin
         age = cyc - t_grant;
         check("work_busy", {31'b0, busy_a}, 32'd1);
         check("work_no_grant", {30'b0, rdy_a}, 32'd0);
         check("det_rst_clear", {31'b0, drst_a}, {31'b0, (age == 1)});
         if (age >= 2 && age <= WIDTH + 1) begin
            check("det_bit", {31'b0, bit_a}, {31'b0, exp_word[WIDTH-1-(age-2)]});
         end else begin
            check("det_bit_zero", {31'b0, bit_a}, 32'd0);
         end
         check("res_valid_a", {31'b0, rv_a}, {31'b0, (age >= LAT)});
         check("res_valid_s", {31'b0, rv_s}, {31'b0, (age >= LAT)});
         if (age >= LAT) begin
            check("res_ch", {31'b0, ch_a}, exp_ch);
            check("res_count_a", {28'b0, cnt_a}, exp_cnt_a);
            check("res_count_s", {30'b0, cnt_s}, exp_cnt_s);
            if (rr) m_idle = 1'b1;
         end
      end
      cyc++;
   endtask

   logic [WIDTH-1:0] pat [4];

   initial begin
      logic [NUM_CH*WIDTH-1:0] rd;
      logic [WIDTH-1:0]        w0, w1;
      logic                    rrdy, rst_r;
      pat[0] = 16'h9999;
      pat[1] = 16'h9249;
      pat[2] = 16'h9009;
      pat[3] = 16'h0000;
      reset = 1'b1;
      req_valid = '0;
      req_data = '0;
      res_ready = 1'b0;

      // Reset with requests pending: no grant may occur.
      for (int i = 0; i < 3; i++) tick(1'b1, 2'b11, {16'h1234, 16'h5678}, 1'b1);

      // ch0 9009 -> 2 hits, result WIDTH+3 after grant.
      tick(1'b0, 2'b01, {16'h0000, 16'h9009}, 1'b1);
      for (int i = 0; i < 21; i++) tick(1'b0, 2'b00, '0, 1'b1);
      // ch1 9999 -> 4 hits, 3 when saturated at 2 bits.
      tick(1'b0, 2'b10, {16'h9999, 16'h0000}, 1'b1);
      for (int i = 0; i < 21; i++) tick(1'b0, 2'b00, '0, 1'b1);
      // ch0 0000 -> 0 hits.
      tick(1'b0, 2'b01, {16'hffff, 16'h0000}, 1'b1);
      for (int i = 0; i < 21; i++) tick(1'b0, 2'b00, '0, 1'b1);

      // Both channels continuously valid: strict alternation.
      for (int i = 0; i < 5 * (WIDTH + 4); i++) begin
         tick(1'b0, 2'b11, {$urandom(), $urandom()}, 1'b1);
      end
      for (int i = 0; i < 22; i++) tick(1'b0, 2'b00, '0, 1'b1);

      // Consumer stalls in REPORT while both channels keep requesting.
      tick(1'b0, 2'b11, {16'h9249, 16'h9999}, 1'b0);
      for (int i = 0; i < LAT + 12; i++) tick(1'b0, 2'b11, {$urandom(), $urandom()}, 1'b0);
      tick(1'b0, 2'b11, '0, 1'b1);
      for (int i = 0; i < 22; i++) tick(1'b0, 2'b00, '0, 1'b1);

      // Reset in the middle of SHIFT aborts the word.
      tick(1'b0, 2'b10, {16'h9999, 16'h9999}, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b0, 2'b00, '0, 1'b1);
      tick(1'b1, 2'b00, '0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, '0, 1'b1);
      tick(1'b0, 2'b11, {16'h0009, 16'h9000}, 1'b1);
      for (int i = 0; i < 21; i++) tick(1'b0, 2'b00, '0, 1'b1);

      // Random traffic with hit-rich words, stalls and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         w0 = ($urandom_range(0, 2) == 0) ? pat[$urandom_range(0, 3)] : WIDTH'($urandom());
         w1 = ($urandom_range(0, 2) == 0) ? pat[$urandom_range(0, 3)] : WIDTH'($urandom());
         rd = {w1, w0};
         rrdy = ($urandom_range(0, 3) != 0);
         rst_r = ($urandom_range(0, 499) == 0);
         tick(rst_r, NUM_CH'($urandom()), rd, rrdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
